// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX stage: default widths, ALU op encodings and
// the control bundle that is zeroed when a bubble is inserted.
package id_ex_pipe_pkg;

    localparam int DSIZE_DEF  = 16;
    localparam int ASIZE_DEF  = 4;
    localparam int OPSIZE_DEF = 3;

    typedef enum logic [OPSIZE_DEF-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_XOR = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_COM = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic valid;
        logic wen;
        logic memrd;
        logic memwr;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, wen: 1'b0, memrd: 1'b0, memwr: 1'b0};

endpackage

// File: rtl/id_ex_pipe_fwd_mux.sv
// Operand bypass selector: EX/MEM result beats MEM/WB result beats the
// registered operand; register r0 is never bypassed.
module id_ex_pipe_fwd_mux #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic [ASIZE-1:0] src,
    input  logic [DSIZE-1:0] reg_data,
    input  logic             exmem_wen,
    input  logic [ASIZE-1:0] exmem_rd,
    input  logic [DSIZE-1:0] exmem_result,
    input  logic             memwb_wen,
    input  logic [ASIZE-1:0] memwb_rd,
    input  logic [DSIZE-1:0] memwb_result,
    output logic [DSIZE-1:0] fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (exmem_wen && (exmem_rd != '0) && (exmem_rd == src)) begin
            fwd_data = exmem_result;
        end else if (memwb_wen && (memwb_rd != '0) && (memwb_rd == src)) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register feeding the ALU, with bubble insertion on load-use.
// ALU_FWD_EN: enables EX/MEM and MEM/WB bypass plus write-through; without it every RAW hazard stalls.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int ASIZE  = ASIZE_DEF,
    parameter int OPSIZE = OPSIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ASIZE-1:0]  id_rs1_addr,
    input  logic [ASIZE-1:0]  id_rs2_addr,
    input  logic [DSIZE-1:0]  id_rs1_data,
    input  logic [DSIZE-1:0]  id_rs2_data,
    input  logic [ASIZE-1:0]  id_rd_addr,
    input  logic [OPSIZE-1:0] id_op,
    input  logic [DSIZE-1:0]  id_imm,
    input  logic              id_alusrc,
    input  logic              id_wen,
    input  logic              id_memrd,
    input  logic              id_memwr,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_wen,
    input  logic [ASIZE-1:0]  exmem_rd,
    input  logic [DSIZE-1:0]  exmem_result,
    input  logic              memwb_wen,
    input  logic [ASIZE-1:0]  memwb_rd,
    input  logic [DSIZE-1:0]  memwb_result,
    output logic [DSIZE-1:0]  ex_a,
    output logic [DSIZE-1:0]  ex_b,
    output logic [OPSIZE-1:0] ex_op,
    output logic [DSIZE-1:0]  ex_imm,
    output logic [DSIZE-1:0]  ex_store_data,
    output logic [ASIZE-1:0]  ex_rd,
    output logic              ex_valid,
    output logic              ex_wen,
    output logic              ex_memrd,
    output logic              ex_memwr,
    output logic              load_use
);

`ifdef ALU_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    ctrl_t              ctrl_reg;
    logic [ASIZE-1:0]   rd_reg;
    logic [ASIZE-1:0]   rs1_addr_reg;
    logic [ASIZE-1:0]   rs2_addr_reg;
    logic [OPSIZE-1:0]  op_reg;
    logic [DSIZE-1:0]   imm_reg;
    logic [DSIZE-1:0]   rs1_data_reg;
    logic [DSIZE-1:0]   rs2_data_reg;
    logic               alusrc_reg;
    logic [DSIZE-1:0]   rs1_data_next;
    logic [DSIZE-1:0]   rs2_data_next;
    logic               bubble;

    function automatic logic addr_hit(input logic en, input logic [ASIZE-1:0] rd,
                                      input logic [ASIZE-1:0] src);
        return en && (rd != '0) && (rd == src);
    endfunction

`ifdef ALU_FWD_EN
    // Only a load in EX cannot be bypassed; rs2 matters only if it is actually read.
    assign load_use = id_valid && ctrl_reg.valid && ctrl_reg.memrd &&
                      (addr_hit(1'b1, rd_reg, id_rs1_addr) ||
                       (addr_hit(1'b1, rd_reg, id_rs2_addr) && (!id_alusrc || id_memwr)));
`else
    logic ex_src;
    assign ex_src   = ctrl_reg.valid && (ctrl_reg.wen || ctrl_reg.memrd);
    assign load_use = id_valid &&
                      (addr_hit(ex_src,    rd_reg,   id_rs1_addr) ||
                       addr_hit(ex_src,    rd_reg,   id_rs2_addr) ||
                       addr_hit(exmem_wen, exmem_rd, id_rs1_addr) ||
                       addr_hit(exmem_wen, exmem_rd, id_rs2_addr) ||
                       addr_hit(memwb_wen, memwb_rd, id_rs1_addr) ||
                       addr_hit(memwb_wen, memwb_rd, id_rs2_addr));
`endif

    // Write-through covers a register file write landing on the same edge as capture.
    assign rs1_data_next = addr_hit(FWD_EN && memwb_wen, memwb_rd, id_rs1_addr) ? memwb_result : id_rs1_data;
    assign rs2_data_next = addr_hit(FWD_EN && memwb_wen, memwb_rd, id_rs2_addr) ? memwb_result : id_rs2_data;

    assign bubble = flush || (!stall && load_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg     <= CTRL_BUBBLE;
            rd_reg       <= '0;
            rs1_addr_reg <= '0;
            rs2_addr_reg <= '0;
            op_reg       <= OPSIZE'(ALU_ADD);
            imm_reg      <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            alusrc_reg   <= 1'b0;
        end else if (bubble) begin
            ctrl_reg     <= CTRL_BUBBLE;
            rd_reg       <= '0;
            rs1_addr_reg <= '0;
            rs2_addr_reg <= '0;
            op_reg       <= OPSIZE'(ALU_ADD);
            imm_reg      <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            alusrc_reg   <= 1'b0;
        end else if (!stall) begin
            ctrl_reg     <= '{valid: id_valid, wen: id_wen, memrd: id_memrd, memwr: id_memwr};
            rd_reg       <= id_rd_addr;
            rs1_addr_reg <= id_rs1_addr;
            rs2_addr_reg <= id_rs2_addr;
            op_reg       <= id_op;
            imm_reg      <= id_imm;
            rs1_data_reg <= rs1_data_next;
            rs2_data_reg <= rs2_data_next;
            alusrc_reg   <= id_alusrc;
        end
    end

    logic [ASIZE-1:0] fwd_src [2];
    logic [DSIZE-1:0] fwd_in  [2];
    logic [DSIZE-1:0] fwd_out [2];

    assign fwd_src[0] = rs1_addr_reg;
    assign fwd_src[1] = rs2_addr_reg;
    assign fwd_in[0]  = rs1_data_reg;
    assign fwd_in[1]  = rs2_data_reg;

    // With forwarding disabled the bypass enables are tied off, leaving plain register outputs.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            id_ex_pipe_fwd_mux #(
                .DSIZE(DSIZE),
                .ASIZE(ASIZE)
            ) u_fwd (
                .src          (fwd_src[gi]),
                .reg_data     (fwd_in[gi]),
                .exmem_wen    (FWD_EN && exmem_wen),
                .exmem_rd     (exmem_rd),
                .exmem_result (exmem_result),
                .memwb_wen    (FWD_EN && memwb_wen),
                .memwb_rd     (memwb_rd),
                .memwb_result (memwb_result),
                .fwd_data     (fwd_out[gi])
            );
        end
    endgenerate

    assign ex_a          = fwd_out[0];
    assign ex_b          = alusrc_reg ? imm_reg : fwd_out[1];
    assign ex_store_data = fwd_out[1];
    assign ex_op         = op_reg;
    assign ex_imm        = imm_reg;
    assign ex_rd         = rd_reg;
    assign ex_valid      = ctrl_reg.valid;
    assign ex_wen        = ctrl_reg.wen;
    assign ex_memrd      = ctrl_reg.memrd;
    assign ex_memwr      = ctrl_reg.memwr;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe; expectations follow whichever build (ALU_FWD_EN
// defined or not) is compiled.
module tb_id_ex_pipe;

`ifdef ALU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_alusrc, id_wen, id_memrd, id_memwr;
    logic [3:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [15:0] id_rs1_data, id_rs2_data, id_imm;
    logic [2:0]  id_op;
    logic        stall, flush;
    logic        exmem_wen, memwb_wen;
    logic [3:0]  exmem_rd, memwb_rd;
    logic [15:0] exmem_result, memwb_result;
    logic [15:0] ex_a, ex_b, ex_imm, ex_store_data;
    logic [2:0]  ex_op;
    logic [3:0]  ex_rd;
    logic        ex_valid, ex_wen, ex_memrd, ex_memwr, load_use;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd_addr(id_rd_addr), .id_op(id_op), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_wen(id_wen), .id_memrd(id_memrd), .id_memwr(id_memwr),
        .stall(stall), .flush(flush),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op), .ex_imm(ex_imm),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_wen(ex_wen), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .load_use(load_use)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [15:0] d1, input logic [15:0] d2, input logic [3:0] rd,
                          input logic [2:0] op, input logic [15:0] imm, input logic alusrc,
                          input logic wen, input logic memrd, input logic memwr);
        id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_data = d1; id_rs2_data = d2;
        id_rd_addr = rd; id_op = op; id_imm = imm; id_alusrc = alusrc;
        id_wen = wen; id_memrd = memrd; id_memwr = memwr;
    endtask

    task automatic set_fwd(input logic ew, input logic [3:0] er, input logic [15:0] ed,
                           input logic mw, input logic [3:0] mr, input logic [15:0] md);
        exmem_wen = ew; exmem_rd = er; exmem_result = ed;
        memwb_wen = mw; memwb_rd = mr; memwb_result = md;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        idle(); set_fwd(0, 0, 0, 0, 0, 0); stall = 0; flush = 0;
        #2;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        checks++; if ({ex_wen, ex_memrd, ex_memwr} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {ex_wen, ex_memrd, ex_memwr}); end
        checks++; if ({ex_rd, ex_op, ex_imm} !== 23'h0) begin errors++; $display("FAIL reset_fields got %h want 0", {ex_rd, ex_op, ex_imm}); end
        checks++; if ({ex_a, ex_b, ex_store_data} !== 48'h0) begin errors++; $display("FAIL reset_data got %h want 0", {ex_a, ex_b, ex_store_data}); end
        checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL reset_load_use got %b want 0", load_use); end
        rst_n = 1'b1;
        $display("txn test_reset");
    endtask

    task automatic test_capture();
        set_id(1, 1, 2, 16'h1234, 16'h0F0F, 5, 3'd1, 16'h00AB, 0, 1, 0, 0);
        tick();
        checks++; if ({ex_valid, ex_wen, ex_memrd, ex_memwr} !== 4'b1100) begin errors++; $display("FAIL cap_ctrl got %b want 1100", {ex_valid, ex_wen, ex_memrd, ex_memwr}); end
        checks++; if (ex_rd !== 4'd5) begin errors++; $display("FAIL cap_rd got %h want 5", ex_rd); end
        checks++; if (ex_op !== 3'd1) begin errors++; $display("FAIL cap_op got %h want 1", ex_op); end
        checks++; if (ex_imm !== 16'h00AB) begin errors++; $display("FAIL cap_imm got %h want 00ab", ex_imm); end
        checks++; if (ex_a !== 16'h1234) begin errors++; $display("FAIL cap_a got %h want 1234", ex_a); end
        checks++; if (ex_b !== 16'h0F0F) begin errors++; $display("FAIL cap_b got %h want 0f0f", ex_b); end
        checks++; if (ex_store_data !== 16'h0F0F) begin errors++; $display("FAIL cap_st got %h want 0f0f", ex_store_data); end
        $display("txn test_capture");
    endtask

    task automatic test_back_to_back();
        set_id(1, 3, 4, 16'h0A0A, 16'h0B0B, 6, 3'd3, 16'h0010, 1, 1, 0, 0);
        tick();
        checks++; if ({ex_rd, ex_op} !== {4'd6, 3'd3}) begin errors++; $display("FAIL b2b_rd_op got %h want %h", {ex_rd, ex_op}, {4'd6, 3'd3}); end
        checks++; if (ex_a !== 16'h0A0A) begin errors++; $display("FAIL b2b_a got %h want 0a0a", ex_a); end
        checks++; if (ex_b !== 16'h0010) begin errors++; $display("FAIL b2b_b_imm got %h want 0010", ex_b); end
        checks++; if (ex_store_data !== 16'h0B0B) begin errors++; $display("FAIL b2b_st got %h want 0b0b", ex_store_data); end
        set_id(1, 7, 8, 16'h0001, 16'h0002, 0, 3'd0, 16'h0000, 1, 0, 0, 1);
        tick();
        checks++; if ({ex_valid, ex_wen, ex_memwr, ex_rd} !== {3'b101, 4'd0}) begin errors++; $display("FAIL b2b_store got %b want 1010000", {ex_valid, ex_wen, ex_memwr, ex_rd}); end
        idle();
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", ex_valid); end
        $display("txn test_back_to_back");
    endtask

    task automatic test_forwarding();
        set_id(1, 3, 2, 16'h0005, 16'h0002, 8, 3'd0, 16'h0000, 0, 1, 0, 0);
        tick();
        idle();
        set_fwd(1, 3, 16'h00A0, 0, 0, 0); #1;
        checks++; if (ex_a !== (FWD ? 16'h00A0 : 16'h0005)) begin errors++; $display("FAIL fwd_exmem got %h want %h", ex_a, FWD ? 16'h00A0 : 16'h0005); end
        set_fwd(1, 3, 16'h1111, 1, 3, 16'h2222); #1;
        checks++; if (ex_a !== (FWD ? 16'h1111 : 16'h0005)) begin errors++; $display("FAIL fwd_prio got %h want %h", ex_a, FWD ? 16'h1111 : 16'h0005); end
        set_fwd(1, 0, 16'h1111, 1, 0, 16'h2222); #1;
        checks++; if (ex_a !== 16'h0005) begin errors++; $display("FAIL fwd_r0 got %h want 0005", ex_a); end
        set_fwd(0, 3, 16'h1111, 1, 3, 16'h2222); #1;
        checks++; if (ex_a !== (FWD ? 16'h2222 : 16'h0005)) begin errors++; $display("FAIL fwd_memwb got %h want %h", ex_a, FWD ? 16'h2222 : 16'h0005); end
        set_fwd(1, 2, 16'h3333, 0, 0, 0); #1;
        checks++; if (ex_b !== (FWD ? 16'h3333 : 16'h0002)) begin errors++; $display("FAIL fwd_rs2 got %h want %h", ex_b, FWD ? 16'h3333 : 16'h0002); end
        set_fwd(1, 3, 16'h00A0, 0, 0, 0);
        set_id(1, 3, 0, 16'h0005, 16'h0000, 9, 3'd0, 16'h0000, 0, 1, 0, 0); #1;
        checks++; if (load_use !== !FWD) begin errors++; $display("FAIL fwd_raw_stall got %b want %b", load_use, !FWD); end
        idle(); set_fwd(0, 0, 0, 0, 0, 0);
        $display("txn test_forwarding");
    endtask

    task automatic test_write_through();
        set_fwd(0, 0, 0, 1, 6, 16'hBEEF);
        set_id(1, 6, 0, 16'h0001, 16'h0000, 9, 3'd0, 16'h0000, 0, 1, 0, 0); #1;
        checks++; if (load_use !== !FWD) begin errors++; $display("FAIL wt_stall got %b want %b", load_use, !FWD); end
        tick();
        set_fwd(0, 0, 0, 0, 0, 0); idle(); #1;
        checks++; if (ex_valid !== FWD) begin errors++; $display("FAIL wt_valid got %b want %b", ex_valid, FWD); end
        checks++; if (ex_a !== (FWD ? 16'hBEEF : 16'h0000)) begin errors++; $display("FAIL wt_a got %h want %h", ex_a, FWD ? 16'hBEEF : 16'h0000); end
        tick();
        $display("txn test_write_through");
    endtask

    task automatic test_load_use();
        set_id(1, 2, 0, 16'h0100, 16'h0000, 4, 3'd0, 16'h0008, 1, 1, 1, 0);
        tick();
        checks++; if ({ex_memrd, ex_b} !== {1'b1, 16'h0008}) begin errors++; $display("FAIL lw_cap got %h want 10008", {ex_memrd, ex_b}); end
        set_id(1, 1, 4, 16'h0003, 16'h9999, 5, 3'd0, 16'h0002, 1, 1, 0, 0); #1;
        checks++; if (load_use !== !FWD) begin errors++; $display("FAIL lu_rs2_imm got %b want %b", load_use, !FWD); end
        set_id(1, 1, 4, 16'h0003, 16'h9999, 0, 3'd0, 16'h0002, 1, 0, 0, 1); #1;
        checks++; if (load_use !== 1'b1) begin errors++; $display("FAIL lu_rs2_store got %b want 1", load_use); end
        set_id(0, 4, 4, 16'h9999, 16'h9999, 5, 3'd0, 16'h0000, 0, 1, 0, 0); #1;
        checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL lu_novalid got %b want 0", load_use); end
        set_id(1, 4, 1, 16'h9999, 16'h0003, 5, 3'd0, 16'h0000, 0, 1, 0, 0); #1;
        checks++; if (load_use !== 1'b1) begin errors++; $display("FAIL lu_rs1 got %b want 1", load_use); end
        tick();
        checks++; if ({ex_valid, ex_rd} !== 5'h0) begin errors++; $display("FAIL lu_bubble got %h want 0", {ex_valid, ex_rd}); end
        set_fwd(1, 4, 16'h0108, 0, 0, 0); #1;
        checks++; if (load_use !== !FWD) begin errors++; $display("FAIL lu_after_bubble got %b want %b", load_use, !FWD); end
        tick();
`ifdef ALU_FWD_EN
        set_fwd(0, 0, 0, 1, 4, 16'h4444); #1;
`else
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL raw_bubble2 got %b want 0", ex_valid); end
        set_fwd(0, 0, 0, 1, 4, 16'h4444); #1;
        checks++; if (load_use !== 1'b1) begin errors++; $display("FAIL raw_memwb got %b want 1", load_use); end
        tick();
        set_fwd(0, 0, 0, 0, 0, 0); id_rs1_data = 16'h4444; #1;
        checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL raw_clear got %b want 0", load_use); end
        tick();
`endif
        checks++; if ({ex_valid, ex_rd} !== {1'b1, 4'd5}) begin errors++; $display("FAIL lu_add_cap got %h want 15", {ex_valid, ex_rd}); end
        checks++; if (ex_a !== 16'h4444) begin errors++; $display("FAIL lu_add_a got %h want 4444", ex_a); end
        checks++; if (ex_b !== 16'h0003) begin errors++; $display("FAIL lu_add_b got %h want 0003", ex_b); end
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 2, 0, 16'h0100, 16'h0000, 0, 3'd0, 16'h0008, 1, 1, 1, 0);
        tick();
        set_id(1, 0, 0, 16'h0000, 16'h0000, 5, 3'd0, 16'h0000, 0, 1, 0, 0); #1;
        checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL lu_r0 got %b want 0", load_use); end
        idle();
        tick();
        $display("txn test_load_use");
    endtask

    task automatic test_stall_flush();
        set_id(1, 10, 11, 16'hAAAA, 16'h5555, 12, 3'd7, 16'h0123, 0, 1, 0, 0);
        tick();
        stall = 1'b1;
        set_id(1, 13, 14, 16'h0001, 16'h0002, 1, 3'd1, 16'h0FFF, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({ex_valid, ex_rd, ex_op, ex_imm, ex_a} !== {1'b1, 4'd12, 3'd7, 16'h0123, 16'hAAAA}) begin errors++; $display("FAIL stall_hold%0d got %h want %h", i, {ex_valid, ex_rd, ex_op, ex_imm, ex_a}, {1'b1, 4'd12, 3'd7, 16'h0123, 16'hAAAA}); end
        end
        flush = 1'b1;
        tick();
        checks++; if ({ex_valid, ex_wen, ex_rd, ex_op, ex_imm, ex_a} !== 41'h0) begin errors++; $display("FAIL stall_flush got %h want 0", {ex_valid, ex_wen, ex_rd, ex_op, ex_imm, ex_a}); end
        flush = 1'b0; stall = 1'b0;
        tick();
        checks++; if ({ex_valid, ex_memwr, ex_rd} !== {2'b11, 4'd1}) begin errors++; $display("FAIL resume got %h want 31", {ex_valid, ex_memwr, ex_rd}); end
        flush = 1'b1;
        tick();
        checks++; if ({ex_valid, ex_memwr} !== 2'b00) begin errors++; $display("FAIL flush_only got %b want 00", {ex_valid, ex_memwr}); end
        flush = 1'b0; idle();
        $display("txn test_stall_flush");
    endtask

    task automatic test_alusrc();
        set_id(1, 1, 2, 16'h00F0, 16'h1111, 3, 3'd4, 16'h0004, 1, 1, 0, 0);
        tick();
        idle();
        set_fwd(1, 2, 16'h7777, 0, 0, 0); #1;
        checks++; if (ex_b !== 16'h0004) begin errors++; $display("FAIL alusrc_b got %h want 0004", ex_b); end
        checks++; if (ex_store_data !== (FWD ? 16'h7777 : 16'h1111)) begin errors++; $display("FAIL alusrc_st got %h want %h", ex_store_data, FWD ? 16'h7777 : 16'h1111); end
        checks++; if ({ex_op, ex_a} !== {3'd4, 16'h00F0}) begin errors++; $display("FAIL alusrc_op_a got %h want %h", {ex_op, ex_a}, {3'd4, 16'h00F0}); end
        set_fwd(0, 0, 0, 0, 0, 0);
        $display("txn test_alusrc");
    endtask

    task automatic test_reset_mid();
        set_id(1, 5, 6, 16'h0042, 16'h0043, 9, 3'd1, 16'h0055, 0, 1, 1, 0);
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", ex_valid); end
        stall = 1'b1; idle();
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({ex_valid, ex_wen, ex_memrd, ex_op, ex_rd} !== 10'h0) begin errors++; $display("FAIL rmid_async got %h want 0", {ex_valid, ex_wen, ex_memrd, ex_op, ex_rd}); end
        checks++; if ({ex_imm, ex_a} !== 32'h0) begin errors++; $display("FAIL rmid_data got %h want 0", {ex_imm, ex_a}); end
        #1 rst_n = 1'b1; stall = 1'b0;
        $display("txn test_reset_mid");
    endtask

    initial begin
        test_reset();
        test_capture();
        test_back_to_back();
        test_forwarding();
        test_write_through();
        test_load_use();
        test_stall_flush();
        test_alusrc();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
